serial_adder_ctrl: RTL and testbench

//   Bit-serial add controller: sequences one 1-bit full-adder cell over two

---
 rtl/serial_adder_ctrl_pkg.sv | 7 +
 rtl/serial_adder_ctrl_fa_bit.sv | 11 +
 rtl/serial_adder_ctrl.sv | 89 ++++++++
 tb/tb_serial_adder_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM state encoding for the bit-serial adder controller
package serial_adder_ctrl_pkg;
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// fa_bit: combinational 1-bit full adder cell shared by every bit position
module fa_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);
   assign o_s  = i_a ^ i_b ^ i_ci;
   assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full-adder cell LSB first over two operands with a start/busy/done handshake
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);
   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] r_sh_s;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic [WIDTH-1:0] w_sh_s;

   fa_bit u_fa (
      .i_a  (r_sh_a[0]),
      .i_b  (r_sh_b[0]),
      .i_ci (r_carry),
      .o_s  (w_s),
      .o_co (w_co)
   );

   assign w_last = r_cnt == CNT_W'(WIDTH - 1);
   assign w_sh_s = {w_s, r_sh_s[WIDTH-1:1]};

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next state: abort beats completion; DONE and the unused encoding fall back to IDLE
   always_comb begin
      w_next = (r_state == S_IDLE) ? (i_start ? S_RUN : S_IDLE) :
               (r_state == S_RUN)  ? (i_abort ? S_IDLE : (w_last ? S_DONE : S_RUN)) :
                                     S_IDLE;
   end

   // handshake outputs decoded from state
   always_comb begin
      o_busy = r_state == S_RUN;
      o_done = r_state == S_DONE;
   end

   // operand capture, serial shift and result commit; the result only moves on a non-aborted final bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_sh_s  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         o_sum   <= '0;
         o_cout  <= 1'b0;
      end else if (r_state == S_IDLE && i_start) begin
         r_sh_a  <= i_a;
         r_sh_b  <= i_b;
         r_carry <= i_cin;
         r_cnt   <= '0;
      end else if (r_state == S_RUN && !i_abort) begin
         r_sh_a  <= r_sh_a >> 1;
         r_sh_b  <= r_sh_b >> 1;
         r_sh_s  <= w_sh_s;
         r_carry <= w_co;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            o_sum  <= w_sh_s;
            o_cout <= w_co;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of the serial adder against plain a+b+cin arithmetic
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_start = 1'b0;
   logic         i_abort = 1'b0;
   logic         i_cin = 1'b0;
   logic [W-1:0] i_a = '0;
   logic [W-1:0] i_b = '0;
   logic         o_busy, o_done, o_cout;
   logic [W-1:0] o_sum;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [W:0]   exp_res = '0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (i_start),
      .i_abort (i_abort),
      .i_a     (i_a),
      .i_b     (i_b),
      .i_cin   (i_cin),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_sum   (o_sum),
      .o_cout  (o_cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + (W+1)'(c);
   endfunction

   // drive a one-cycle start, then scramble operands; returns at the negedge after acceptance
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(negedge clk);
      i_start = 1'b1; i_a = a; i_b = b; i_cin = c;
      @(negedge clk);
      i_start = 1'b0; i_a = W'($urandom); i_b = W'($urandom); i_cin = 1'($urandom);
   endtask

   // wait out RUN, checking length, result stability, the done pulse and the final result
   task automatic finish_op(input string tag, input logic [W:0] res, input bit hold_start);
      int n = 0;
      while (o_busy && n < 40) begin
         check({tag, "_sum_stable"}, {23'd0, o_cout, o_sum}, {23'd0, exp_res});
         n++;
         if (hold_start && n == 3) begin
            i_start = 1'b1; i_a = 8'h01; i_b = 8'h01; i_cin = 1'b0;
         end
         @(negedge clk);
      end
      i_start = 1'b0;
      check({tag, "_busy_cycles"}, n, W);
      check({tag, "_done"}, {31'd0, o_done}, 1);
      check({tag, "_result"}, {23'd0, o_cout, o_sum}, {23'd0, res});
      exp_res = res;
      @(negedge clk);
      check({tag, "_done_width"}, {31'd0, o_done}, 0);
      check({tag, "_idle"}, {31'd0, o_busy}, 0);
      @(negedge clk);
      check({tag, "_no_requeue"}, {30'd0, o_busy, o_done}, 0);
   endtask

   initial begin
      logic [W-1:0] a, b;
      logic         c;
      logic [W:0]   drv_res, pend_res;
      int           cyc, last_done, ops;
      bit           prev_busy;
      #2;
      check("reset_outputs", {21'd0, o_busy, o_done, o_cout, o_sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      launch(8'h5A, 8'h3C, 1'b0);
      finish_op("t1", 9'h096, 1'b0);
      launch(8'hFF, 8'h01, 1'b0);
      finish_op("t2a", 9'h100, 1'b0);
      launch(8'hFF, 8'hFF, 1'b1);
      finish_op("t2b", 9'h1FF, 1'b0);
      launch(8'h10, 8'h20, 1'b0);
      finish_op("t3", 9'h030, 1'b1);

      launch(8'h12, 8'h34, 1'b0);
      finish_op("t4a", 9'h046, 1'b0);
      launch(8'hF0, 8'h0F, 1'b0);
      repeat (3) @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      check("t4_abort", {21'd0, o_busy, o_done, o_cout, o_sum}, {21'd0, 3'b000, 8'h46});
      @(negedge clk);
      check("t4_abort_nodone", {30'd0, o_busy, o_done}, 0);

      launch(8'hAA, 8'h55, 1'b1);
      repeat (7) @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      check("abort_last_bit", {21'd0, o_busy, o_done, o_cout, o_sum}, {21'd0, 3'b000, 8'h46});

      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      check("abort_idle", {21'd0, o_busy, o_done, o_cout, o_sum}, {21'd0, 3'b000, 8'h46});

      launch(8'h77, 8'h88, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("t5_async_reset", {21'd0, o_busy, o_done, o_cout, o_sum}, 0);
      exp_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      launch(8'h01, 8'h02, 1'b0);
      finish_op("t5", 9'h003, 1'b0);

      repeat (15) begin
         a = W'($urandom); b = W'($urandom); c = 1'($urandom);
         launch(a, b, c);
         finish_op("rand", model(a, b, c), 1'b0);
      end

      cyc = 0; last_done = -1; ops = 0; prev_busy = 1'b0; pend_res = '0;
      @(negedge clk);
      i_start = 1'b1;
      i_a = W'($urandom); i_b = W'($urandom); i_cin = 1'($urandom);
      drv_res = model(i_a, i_b, i_cin);
      while (ops < 6 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (o_busy && !prev_busy) pend_res = drv_res;
         if (o_done) begin
            check("b2b_result", {23'd0, o_cout, o_sum}, {23'd0, pend_res});
            if (last_done >= 0) check("b2b_cadence", cyc - last_done, W + 2);
            last_done = cyc;
            ops++;
         end
         prev_busy = o_busy;
         i_a = W'($urandom); i_b = W'($urandom); i_cin = 1'($urandom);
         drv_res = model(i_a, i_b, i_cin);
      end
      i_start = 1'b0;
      check("b2b_ops", ops, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
